// File: rtl/seq_det_pkg.sv
// Shared types and constants for the 1011 serial sequence detector.
//   seq_state_t  : detector progress (how much of 1011 has been seen so far)
//   SEQ_PATTERN  : the pattern searched for, MSB presented first
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // nothing useful seen
        S_1    = 2'd1,  // "1"
        S_10   = 2'd2,  // "10"
        S_101  = 2'd3   // "101", a following 1 completes the pattern
    } seq_state_t;

    localparam logic [3:0] SEQ_PATTERN = 4'b1011;

endpackage : seq_det_pkg

// File: rtl/seq_gap_timer.sv
// Stall watchdog for the sequence detector.
// Counts consecutive cycles without a qualified bit while a partial pattern
// is in progress and raises a combinational abort strobe on the GAP_MAX-th
// stalled cycle. A stall of GAP_MAX-1 cycles is tolerated.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low
//   active     in   detector is in a non-idle state
//   bit_valid  in   a qualified bit is presented this cycle
//   timeout    out  abort strobe, valid in the same cycle (combinational)
module seq_gap_timer #(
    parameter int GAP_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic bit_valid,
    output logic timeout
);

    // GAP_MAX=1 would give a zero-width counter; keep at least one bit.
    localparam int GW = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);

    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;
    logic          stalled;

    assign stalled = active & ~bit_valid;
    assign timeout = stalled & (gap_q == GAP_LAST);

    // Any qualified bit or an idle detector restarts the count; the aborting
    // cycle also clears it because the detector returns to idle.
    always_comb begin
        gap_d = gap_q;
        if (!stalled || timeout) begin
            gap_d = '0;
        end else begin
            gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule : seq_gap_timer

// File: rtl/seq1011_detector.sv
// Mealy detector for the serial pattern 1-0-1-1 on a qualified bit stream.
// Handshake: bit_in is consumed only in cycles where bit_valid=1; there is
// no back-pressure, the detector accepts every qualified bit.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous reset, active-low
//   bit_in       in   serial data bit
//   bit_valid    in   bit_in is qualified this cycle
//   cnt_clr      in   synchronous clear of match_count (wins over a match)
//   match        out  combinational: final '1' of 1011 presented this cycle
//   match_q      out  match delayed by one clock
//   match_count  out  saturating number of matches since reset/clear
//   busy         out  a partial pattern is in progress (state != S_IDLE)
module seq1011_detector
    import seq_det_pkg::*;
#(
    parameter bit OVERLAP = 1'b1,
    parameter int CNT_W   = 8,
    parameter int GAP_MAX = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             cnt_clr,
    output logic             match,
    output logic             match_q,
    output logic [CNT_W-1:0] match_count,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic             match_d;
    logic             match_q_r;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout;

    seq_gap_timer #(
        .GAP_MAX (GAP_MAX)
    ) u_gap_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .active    (state_q != S_IDLE),
        .bit_valid (bit_valid),
        .timeout   (timeout)
    );

    // Next state and Mealy output. bit_in is only looked at under bit_valid,
    // so an undriven bit_in during stalls cannot reach the state or match.
    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (bit_valid) begin
            unique case (state_q)
                S_IDLE:  state_d = bit_in ? S_1 : S_IDLE;
                S_1:     state_d = bit_in ? S_1 : S_10;
                S_10:    state_d = bit_in ? S_101 : S_IDLE;
                S_101: begin
                    if (bit_in) begin
                        match_d = 1'b1;
                        // With overlap the trailing 1 starts the next pattern.
                        state_d = OVERLAP ? S_1 : S_IDLE;
                    end else begin
                        state_d = S_10;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (timeout) begin
            state_d = S_IDLE;
        end
    end

    // Clear takes priority over a coincident match; saturate instead of wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            match_q_r <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            match_q_r <= match;
            cnt_q     <= cnt_d;
        end
    end

    assign match       = rst_n & match_d;
    assign match_q     = match_q_r;
    assign match_count = cnt_q;
    assign busy        = (state_q != S_IDLE);

endmodule : seq1011_detector
